// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   state_e            - controller FSM state encoding (RUN=0, LOAD_STALL=1, FLUSH=2)
//   DEF_LOAD_LAT       - default load-use bubble count
//   DEF_FLUSH_CYCLES   - default redirect flush length
//   REM_W              - width of the remaining-cycles down-counter
//   rem_init()         - down-counter load value for an N-cycle sequence
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  localparam int DEF_LOAD_LAT     = 1;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int REM_W            = 3;

  // The first cycle of a sequence is spent in RUN, so the follow-on
  // state only has to count the remaining n-1 cycles.
  function automatic logic [REM_W-1:0] rem_init(input int n);
    return REM_W'(n - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   inc         - count up by one this cycle (ignored at all-ones)
//   clr         - synchronous clear, wins over inc
//   cnt         - current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (clr)           r_cnt <= '0;
    else if (inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards and redirects and
// produces stall / flush / freeze controls for a 5-stage pipeline.
// Outputs are Mealy (combinational from state, rem and current inputs).
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   id_rs1_addr/id_rs2_addr     - decode source registers
//   id_uses_rs1/id_uses_rs2     - decode reads the corresponding source
//   ex_rd_addr, ex_mem_read     - execute destination and load flag
//   ex_redirect                 - taken branch/jump resolved in execute
//   mem_busy                    - data memory not ready, freezes everything
//   cnt_clr                     - synchronous clear of both counters
//   stall_if, stall_id          - hold PC+IF/ID, hold decode outputs
//   flush_if, flush_id          - kill IF/ID, bubble into ID/EX
//   freeze_back                 - hold EX/MEM/WB
//   state_o                     - current FSM state
//   stall_cnt, flush_cnt        - stall cycles seen, redirects accepted
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT     = DEF_LOAD_LAT,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_back,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e           r_state, w_nxt_state;
  logic [REM_W-1:0] r_rem, w_nxt_rem;

  logic w_hazard;
  logic w_flush_acc;
  logic w_stall_if, w_stall_id, w_flush_if, w_flush_id, w_freeze;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_hazard = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_flush_if  = 1'b0;
    w_flush_id  = 1'b0;
    w_freeze    = 1'b0;
    w_flush_acc = 1'b0;
    w_nxt_state = r_state;
    w_nxt_rem   = r_rem;

    if (mem_busy) begin
      // Memory stall freezes the whole pipe; the sequence in flight resumes
      // exactly where it left off once memory is ready.
      w_stall_if = 1'b1;
      w_stall_id = 1'b1;
      w_freeze   = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (ex_redirect) begin
            w_flush_if  = 1'b1;
            w_flush_id  = 1'b1;
            w_flush_acc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_nxt_state = FLUSH;
              w_nxt_rem   = rem_init(FLUSH_CYCLES);
            end
          end else if (w_hazard) begin
            w_stall_if = 1'b1;
            w_flush_id = 1'b1;
            if (LOAD_LAT > 1) begin
              w_nxt_state = LOAD_STALL;
              w_nxt_rem   = rem_init(LOAD_LAT);
            end
          end
        end
        LOAD_STALL: begin
          w_stall_if = 1'b1;
          w_flush_id = 1'b1;
          w_nxt_rem  = r_rem - 1'b1;
          if (r_rem <= REM_W'(1)) begin
            w_nxt_state = RUN;
            w_nxt_rem   = '0;
          end
        end
        FLUSH: begin
          w_flush_if = 1'b1;
          w_flush_id = 1'b1;
          w_nxt_rem  = r_rem - 1'b1;
          if (r_rem <= REM_W'(1)) begin
            w_nxt_state = RUN;
            w_nxt_rem   = '0;
          end
        end
        default: begin
          w_nxt_state = RUN;
          w_nxt_rem   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_rem   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_rem   <= w_nxt_rem;
    end
  end

  // Controls are forced low while reset is held so the pipe sees no bubbles.
  assign stall_if    = w_stall_if & rst_n;
  assign stall_id    = w_stall_id & rst_n;
  assign flush_if    = w_flush_if & rst_n;
  assign flush_id    = w_flush_id & rst_n;
  assign freeze_back = w_freeze   & rst_n;
  assign state_o     = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_acc),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two instances run from the same stimulus:
//   A: LOAD_LAT=1, FLUSH_CYCLES=2, CNT_W=32
//   B: LOAD_LAT=3, FLUSH_CYCLES=3, CNT_W=4 (small so saturation is reached)
// The reference model treats every multi-cycle sequence as a queue of owed
// bubbles: a redirect or load-use owes N-1 more cycles of the same kind,
// memory stalls owe nothing and consume nothing.
module tb_pipeline_hazard_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0, mem_busy = 1'b0, cnt_clr = 1'b0;

  logic        a_sif, a_sid, a_fif, a_fid, a_frz;
  logic [1:0]  a_st;
  logic [31:0] a_sc, a_fc;
  logic        b_sif, b_sid, b_fif, b_fid, b_frz;
  logic [1:0]  b_st;
  logic [3:0]  b_sc, b_fc;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .stall_if(a_sif), .stall_id(a_sid), .flush_if(a_fif), .flush_id(a_fid),
    .freeze_back(a_frz), .state_o(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .stall_if(b_sif), .stall_id(b_sid), .flush_if(b_fif), .flush_id(b_fid),
    .freeze_back(b_frz), .state_o(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  // ctl = {stall_if, stall_id, flush_if, flush_id, freeze_back}
  typedef struct packed {
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [63:0] sc;
    logic [63:0] fc;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  // Reference model state: owed bubbles (1 = stall, 2 = flush) and counters.
  int          tok0[$];
  int          tok1[$];
  logic [63:0] m_sc[2];
  logic [63:0] m_fc[2];

  function automatic int ll(input int d);  return (d == 0) ? 1 : 3; endfunction
  function automatic int fcy(input int d); return (d == 0) ? 2 : 3; endfunction
  function automatic logic [63:0] cmax(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] mx);
    return (v >= mx) ? mx : v + 64'd1;
  endfunction

  function automatic int tsize(input int d);  return (d == 0) ? tok0.size() : tok1.size(); endfunction
  function automatic int tfront(input int d); return (d == 0) ? tok0[0] : tok1[0]; endfunction
  task automatic tpop(input int d);
    if (d == 0) void'(tok0.pop_front()); else void'(tok1.pop_front());
  endtask
  task automatic tpush(input int d, input int k);
    if (d == 0) tok0.push_back(k); else tok1.push_back(k);
  endtask
  task automatic tclear(input int d);
    if (d == 0) tok0.delete(); else tok1.delete();
  endtask

  task automatic mstep(input int d, output exp_t e);
    int   head;
    logic haz;
    e = '0;
    if (!rst_n) begin
      tclear(d);
      m_sc[d] = '0;
      m_fc[d] = '0;
      return;
    end
    haz = ex_mem_read && (ex_rd_addr != 5'd0) &&
          ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
           (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    head = (tsize(d) > 0) ? tfront(d) : 0;
    e.st = head[1:0];
    e.sc = m_sc[d];
    e.fc = m_fc[d];
    if (mem_busy) begin
      e.ctl = 5'b11001;
    end else if (head != 0) begin
      tpop(d);
      e.ctl = (head == 1) ? 5'b10010 : 5'b00110;
    end else if (ex_redirect) begin
      e.ctl = 5'b00110;
      for (int i = 1; i < fcy(d); i++) tpush(d, 2);
      m_fc[d] = sat_inc(m_fc[d], cmax(d));
    end else if (haz) begin
      e.ctl = 5'b10010;
      for (int i = 1; i < ll(d); i++) tpush(d, 1);
    end
    if (e.ctl[4]) m_sc[d] = sat_inc(m_sc[d], cmax(d));
    if (cnt_clr) begin
      m_sc[d] = '0;
      m_fc[d] = '0;
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic u1, input logic u2, input logic rdr,
                      input logic bz, input logic cl);
    pair_t p;
    exp_t  ea, eb;
    @(posedge clk);
    #1;
    rst_n = r; ex_mem_read = mr; ex_rd_addr = rd;
    id_rs1_addr = a1; id_rs2_addr = a2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_redirect = rdr; mem_busy = bz; cnt_clr = cl;
    mstep(0, ea);
    mstep(1, eb);
    p.a = ea;
    p.b = eb;
    exp_q.push_back(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L);
  endtask

  task automatic chk(input string nm, input exp_t e, input logic [4:0] ctl,
                     input logic [1:0] st, input logic [63:0] sc, input logic [63:0] fc);
    n_cmp++;
    if (ctl !== e.ctl || st !== e.st || sc !== e.sc || fc !== e.fc) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
               nm, cyc, ctl, st, sc, fc, e.ctl, e.st, e.sc, e.fc);
    end
  endtask

  // Monitor: the controller presents a full response every cycle.
  always @(negedge clk) begin
    pair_t p;
    cyc++;
    if (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      chk("dut_a", p.a, {a_sif, a_sid, a_fif, a_fid, a_frz}, a_st, {32'd0, a_sc}, {32'd0, a_fc});
      chk("dut_b", p.b, {b_sif, b_sid, b_fif, b_fid, b_frz}, b_st, {60'd0, b_sc}, {60'd0, b_fc});
    end
  end

  initial begin
    m_sc[0] = '0; m_sc[1] = '0; m_fc[0] = '0; m_fc[1] = '0;

    // reset state
    step(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L);
    step(L, H, 5'd5, 5'd5, 5'd0, H, L, H, H, L);
    idle(2);

    // load-use on rs1, then on rs2; x0 destination never stalls
    step(H, H, 5'd5, 5'd5, 5'd0, H, L, L, L, L);
    idle(3);
    step(H, H, 5'd7, 5'd1, 5'd7, L, H, L, L, L);
    idle(3);
    step(H, H, 5'd0, 5'd0, 5'd0, H, H, L, L, L);
    idle(2);
    step(H, H, 5'd5, 5'd5, 5'd0, L, L, L, L, L);
    idle(2);

    // redirect pulse with a second pulse in the follow-on cycle
    step(H, L, 5'd0, 5'd0, 5'd0, L, L, H, L, L);
    step(H, L, 5'd0, 5'd0, 5'd0, L, L, H, L, L);
    idle(4);

    // memory freeze in the second flush cycle
    step(H, L, 5'd0, 5'd0, 5'd0, L, L, H, L, L);
    for (int i = 0; i < 3; i++) step(H, L, 5'd0, 5'd0, 5'd0, L, L, L, H, L);
    idle(4);

    // redirect and load-use together: flush only
    step(H, H, 5'd3, 5'd3, 5'd3, H, H, H, L, L);
    idle(4);

    // reset in the second stall cycle of the long-latency instance
    step(H, H, 5'd5, 5'd5, 5'd0, H, L, L, L, L);
    step(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L);
    idle(4);

    // counter clear racing an increment
    step(H, L, 5'd0, 5'd0, 5'd0, L, L, L, H, H);
    idle(2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(2);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
